// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - trend encodings and signed saturation helper for the slope classifier
package edge_pkg;

  typedef enum logic [1:0] {
    TREND_FLAT    = 2'b00,
    TREND_RISING  = 2'b01,
    TREND_FALLING = 2'b10
  } trend_e;

  // Clamp a wide signed value into the range of a 'bits'-wide two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned bits);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bits - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/boxcar_average.sv
// rtl/boxcar_average.sv - power-of-two boxcar smoother: sample history plus running sum
module boxcar_average
  import edge_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int LOG2_AVG  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [DATA_BITS-1:0] in_data,
  output logic                        out_valid,
  output logic signed [DATA_BITS-1:0] out_data
);

  localparam int DEPTH    = 1 << LOG2_AVG;
  localparam int SUM_BITS = DATA_BITS + LOG2_AVG;

  logic signed [DATA_BITS-1:0] hist_q [DEPTH];
  logic signed [DATA_BITS-1:0] hist_d [DEPTH];
  logic signed [SUM_BITS-1:0]  sum_q, sum_d;
  logic                        valid_q, valid_d;

  always_comb begin
    hist_d  = hist_q;
    sum_d   = sum_q;
    valid_d = in_valid;
    if (in_valid) begin
      hist_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      // The sample leaving the window is subtracted, so the sum stays bounded by DEPTH samples.
      sum_d = sum_q + SUM_BITS'(in_data) - SUM_BITS'(hist_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
      hist_q  <= hist_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = DATA_BITS'(sum_q >>> LOG2_AVG);

endmodule

// File: rtl/edge_slope_classifier.sv
// rtl/edge_slope_classifier.sv - lagged-difference slope estimator with hysteresis trend FSM and edge events
module edge_slope_classifier
  import edge_pkg::*;
#(
  parameter int DATA_BITS   = 12,
  parameter int LOG2_AVG    = 2,
  parameter int SLOPE_LAG   = 4,
  parameter int SLOPE_SHIFT = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        data_ready,
  input  logic signed [DATA_BITS-1:0] data_in,
  input  logic        [DATA_BITS-2:0] threshold,
  output logic                        slope_valid,
  output logic signed [DATA_BITS-1:0] estimated_slope,
  output logic                        slope_is_positive,
  output logic        [1:0]           trend,
  output logic                        rising_edge,
  output logic                        falling_edge,
  output logic                        primed
);

  localparam int PRIME_COUNT = (1 << LOG2_AVG) + SLOPE_LAG;
  localparam int CNT_BITS    = $clog2(PRIME_COUNT + 1);
  localparam int DIFF_BITS   = DATA_BITS + 1;
  localparam int SCALED_BITS = DIFF_BITS + SLOPE_SHIFT;

  logic                        avg_valid;
  logic signed [DATA_BITS-1:0] smoothed;

  boxcar_average #(
    .DATA_BITS (DATA_BITS),
    .LOG2_AVG  (LOG2_AVG)
  ) u_boxcar (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (data_ready),
    .in_data   (data_in),
    .out_valid (avg_valid),
    .out_data  (smoothed)
  );

  logic signed [DATA_BITS-1:0] sm_hist_q [SLOPE_LAG];
  logic signed [DATA_BITS-1:0] sm_hist_d [SLOPE_LAG];
  logic        [DATA_BITS-2:0] thr_q, thr_d;
  logic        [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                        slope_valid_q, slope_valid_d;
  logic signed [DATA_BITS-1:0] estimated_slope_q, estimated_slope_d;
  logic                        slope_is_positive_q, slope_is_positive_d;
  logic                        rising_edge_q, rising_edge_d;
  logic                        falling_edge_q, falling_edge_d;
  logic                        primed_q, primed_d;
  trend_e                      trend_q, trend_d;

  logic signed [DIFF_BITS-1:0]   diff;
  logic signed [SCALED_BITS-1:0] scaled;
  logic signed [DATA_BITS-1:0]   slope_sat;
  logic signed [DIFF_BITS-1:0]   slope_ext;
  logic signed [DIFF_BITS-1:0]   th_ext;

  assign diff      = DIFF_BITS'(smoothed) - DIFF_BITS'(sm_hist_q[SLOPE_LAG-1]);
  assign scaled    = SCALED_BITS'(diff) <<< SLOPE_SHIFT;
  assign slope_sat = DATA_BITS'(sat_signed(64'(scaled), DATA_BITS));
  assign slope_ext = DIFF_BITS'(slope_sat);
  // Threshold is unsigned; one extra bit keeps -th representable when th is at its maximum.
  assign th_ext    = $signed({2'b00, thr_q});

  // Threshold travels alongside its sample through the boxcar stage.
  always_comb begin
    thr_d = thr_q;
    if (data_ready) thr_d = threshold;
  end

  always_comb begin
    sm_hist_d           = sm_hist_q;
    cnt_d               = cnt_q;
    slope_valid_d       = 1'b0;
    estimated_slope_d   = estimated_slope_q;
    slope_is_positive_d = slope_is_positive_q;
    rising_edge_d       = 1'b0;
    falling_edge_d      = 1'b0;
    primed_d            = primed_q;
    trend_d             = trend_q;
    if (avg_valid) begin
      sm_hist_d[0] = smoothed;
      for (int i = 1; i < SLOPE_LAG; i++) sm_hist_d[i] = sm_hist_q[i-1];
      if (cnt_q != CNT_BITS'(PRIME_COUNT)) cnt_d = cnt_q + CNT_BITS'(1);
      primed_d            = (cnt_d == CNT_BITS'(PRIME_COUNT));
      slope_valid_d       = 1'b1;
      estimated_slope_d   = slope_sat;
      slope_is_positive_d = (slope_sat > 0);
      if (primed_d) begin
        case (trend_q)
          TREND_FLAT: begin
            if (slope_ext > th_ext)       trend_d = TREND_RISING;
            else if (slope_ext < -th_ext) trend_d = TREND_FALLING;
          end
          TREND_RISING:  if (slope_ext < -th_ext) trend_d = TREND_FALLING;
          TREND_FALLING: if (slope_ext > th_ext)  trend_d = TREND_RISING;
          default:       trend_d = TREND_FLAT;
        endcase
        rising_edge_d  = (trend_d == TREND_RISING)  && (trend_q != TREND_RISING);
        falling_edge_d = (trend_d == TREND_FALLING) && (trend_q != TREND_FALLING);
      end else begin
        trend_d = TREND_FLAT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      thr_q               <= '0;
      cnt_q               <= '0;
      slope_valid_q       <= 1'b0;
      estimated_slope_q   <= '0;
      slope_is_positive_q <= 1'b0;
      rising_edge_q       <= 1'b0;
      falling_edge_q      <= 1'b0;
      primed_q            <= 1'b0;
      for (int i = 0; i < SLOPE_LAG; i++) sm_hist_q[i] <= '0;
    end else begin
      thr_q               <= thr_d;
      cnt_q               <= cnt_d;
      slope_valid_q       <= slope_valid_d;
      estimated_slope_q   <= estimated_slope_d;
      slope_is_positive_q <= slope_is_positive_d;
      rising_edge_q       <= rising_edge_d;
      falling_edge_q      <= falling_edge_d;
      primed_q            <= primed_d;
      sm_hist_q           <= sm_hist_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) trend_q <= TREND_FLAT;
    else       trend_q <= trend_d;
  end

  assign slope_valid       = slope_valid_q;
  assign estimated_slope   = estimated_slope_q;
  assign slope_is_positive = slope_is_positive_q;
  assign trend             = trend_q;
  assign rising_edge       = rising_edge_q;
  assign falling_edge      = falling_edge_q;
  assign primed            = primed_q;

endmodule

// File: tb/tb_edge_slope_classifier.sv
// tb/tb_edge_slope_classifier.sv - scoreboard and vector-table bench for edge_slope_classifier
module tb_edge_slope_classifier;

  localparam int DATA_BITS   = 12;
  localparam int LOG2_AVG    = 2;
  localparam int SLOPE_LAG   = 4;
  localparam int SLOPE_SHIFT = 3;
  localparam int WIN         = 1 << LOG2_AVG;
  localparam int PRIME       = WIN + SLOPE_LAG;
  localparam int SMAX        = 2047;
  localparam int SMIN        = -2048;
  localparam int T_FLAT = 0, T_RISE = 1, T_FALL = 2;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        data_ready = 1'b0;
  logic        [DATA_BITS-1:0] data_in = '0;
  logic        [DATA_BITS-2:0] threshold = '0;
  logic                        slope_valid;
  logic signed [DATA_BITS-1:0] estimated_slope;
  logic                        slope_is_positive;
  logic        [1:0]           trend;
  logic                        rising_edge;
  logic                        falling_edge;
  logic                        primed;

  edge_slope_classifier #(
    .DATA_BITS   (DATA_BITS),
    .LOG2_AVG    (LOG2_AVG),
    .SLOPE_LAG   (SLOPE_LAG),
    .SLOPE_SHIFT (SLOPE_SHIFT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .data_ready        (data_ready),
    .data_in           (data_in),
    .threshold         (threshold),
    .slope_valid       (slope_valid),
    .estimated_slope   (estimated_slope),
    .slope_is_positive (slope_is_positive),
    .trend             (trend),
    .rising_edge       (rising_edge),
    .falling_edge      (falling_edge),
    .primed            (primed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int slope;
    int trend;
    bit rise;
    bit fall;
    bit primed;
    int cyc;
  } exp_t;

  typedef struct {
    int d;
    int thr;
    int slope;
    int trend;
    bit rise;
    bit fall;
  } vec_t;

  exp_t sb[$];
  int   ms[$];
  int   mcnt, mtrend;
  int   cyc, tests, fails;
  int   n_rise, n_fall, n_valid;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int m_smooth(input int k);
    int s;
    s = 0;
    if (k < 0) return 0;
    for (int j = k - WIN + 1; j <= k; j++) if (j >= 0) s += ms[j];
    return s >>> LOG2_AVG;
  endfunction

  task automatic model_step(input int d, input int thr, output exp_t e);
    int k, sc;
    ms.push_back(d);
    k  = ms.size() - 1;
    sc = (m_smooth(k) - m_smooth(k - SLOPE_LAG)) * (1 << SLOPE_SHIFT);
    if (sc > SMAX) sc = SMAX;
    if (sc < SMIN) sc = SMIN;
    if (mcnt < PRIME) mcnt++;
    e.slope  = sc;
    e.primed = (mcnt == PRIME);
    e.rise   = 1'b0;
    e.fall   = 1'b0;
    if (e.primed) begin
      if (mtrend != T_RISE && sc > thr) begin
        mtrend = T_RISE;
        e.rise = 1'b1;
      end else if (mtrend != T_FALL && sc < -thr) begin
        mtrend = T_FALL;
        e.fall = 1'b1;
      end
    end
    e.trend = mtrend;
    e.cyc   = cyc;
  endtask

  task automatic monitor();
    exp_t e;
    if (reset) return;
    if (rising_edge || falling_edge) begin
      check("edge_needs_valid", slope_valid, 1);
      check("edge_exclusive", rising_edge & falling_edge, 0);
    end
    if (slope_valid) begin
      n_valid++;
      if (rising_edge) n_rise++;
      if (falling_edge) n_fall++;
      if (sb.size() == 0) begin
        check("unexpected_valid", slope_valid, 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.cyc, 2);
        check("slope", estimated_slope, e.slope);
        check("slope_is_positive", slope_is_positive, e.slope > 0);
        check("trend", trend, e.trend);
        check("rising_edge", rising_edge, e.rise);
        check("falling_edge", falling_edge, e.fall);
        check("primed", primed, e.primed);
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply(input int d, input int thr);
    exp_t e;
    data_ready = 1'b1;
    data_in    = DATA_BITS'(d);
    threshold  = (DATA_BITS-1)'(thr);
    model_step(d, thr, e);
    sb.push_back(e);
    tick();
    data_ready = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    data_ready = 1'b1;
    data_in    = DATA_BITS'(v.d);
    threshold  = (DATA_BITS-1)'(v.thr);
    model_step(v.d, v.thr, e);
    e.slope  = v.slope;
    e.trend  = v.trend;
    e.rise   = v.rise;
    e.fall   = v.fall;
    e.primed = 1'b1;
    sb.push_back(e);
    tick();
    data_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    data_ready = 1'b1;
    data_in    = DATA_BITS'(500);
    threshold  = '1;
    sb.delete();
    ms.delete();
    mcnt   = 0;
    mtrend = T_FLAT;
    repeat (n) tick();
    reset      = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual still running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sat_tab[16];
    int rb, fb, vb;

    for (int k = 0; k < 7; k++)
      sat_tab[k] = '{d: SMAX, thr: 100, slope: SMAX, trend: T_RISE, rise: (k == 0), fall: 1'b0};
    sat_tab[7] = '{d: SMAX, thr: 100, slope: 0, trend: T_RISE, rise: 1'b0, fall: 1'b0};
    for (int k = 8; k < 15; k++)
      sat_tab[k] = '{d: SMIN, thr: 100, slope: SMIN, trend: T_FALL, rise: 1'b0, fall: (k == 8)};
    sat_tab[15] = '{d: SMIN, thr: 100, slope: 0, trend: T_FALL, rise: 1'b0, fall: 1'b0};

    cyc = 0; tests = 0; fails = 0; n_rise = 0; n_fall = 0; n_valid = 0;

    do_reset(3);
    check("rst_slope_valid", slope_valid, 0);
    check("rst_slope", estimated_slope, 0);
    check("rst_positive", slope_is_positive, 0);
    check("rst_trend", trend, T_FLAT);
    check("rst_rising", rising_edge, 0);
    check("rst_falling", falling_edge, 0);
    check("rst_primed", primed, 0);

    // constant input, then threshold 0 with zero slope
    rb = n_rise; fb = n_fall;
    for (int n = 0; n < 20; n++) apply(100, 50);
    for (int n = 0; n < 4; n++) apply(100, 0);
    drain();
    check("const_primed", primed, 1);
    check("const_trend", trend, T_FLAT);
    check("const_slope", estimated_slope, 0);
    check("const_edges", (n_rise - rb) + (n_fall - fb), 0);

    // dense ramp up then down
    do_reset(2);
    rb = n_rise; fb = n_fall;
    for (int n = 0; n < 20; n++) apply(10 * n, 100);
    drain();
    check("ramp_up_slope", estimated_slope, 320);
    check("ramp_up_trend", trend, T_RISE);
    check("ramp_up_rises", n_rise - rb, 1);
    for (int i = 1; i <= 24; i++) apply(190 - 10 * i, 100);
    drain();
    check("ramp_dn_slope", estimated_slope, -320);
    check("ramp_dn_trend", trend, T_FALL);
    check("ramp_dn_falls", n_fall - fb, 1);
    check("ramp_dn_rises", n_rise - rb, 1);

    // saturation at both rails
    do_reset(2);
    for (int n = 0; n < 10; n++) apply(SMIN, 100);
    for (int k = 0; k < 16; k++) apply_vec(sat_tab[k]);
    drain();
    check("sat_final_trend", trend, T_FALL);

    // sparse ramp with 4 idle cycles between strobes
    do_reset(2);
    rb = n_rise;
    for (int n = 0; n < 20; n++) begin
      apply(10 * n, 100);
      idle(4);
    end
    drain();
    check("sparse_slope", estimated_slope, 320);
    check("sparse_trend", trend, T_RISE);
    check("sparse_rises", n_rise - rb, 1);

    // reset mid-ramp, then re-prime
    for (int n = 0; n < 5; n++) apply(300 + 10 * n, 100);
    do_reset(1);
    check("midrst_primed", primed, 0);
    check("midrst_trend", trend, T_FLAT);
    rb = n_rise;
    for (int n = 0; n < PRIME - 1; n++) apply(10 * n, 100);
    drain();
    check("reprime_no_edge", n_rise - rb, 0);
    check("reprime_not_primed", primed, 0);
    apply(10 * (PRIME - 1), 100);
    drain();
    check("reprime_edge", n_rise - rb, 1);
    check("reprime_primed", primed, 1);

    // sample in flight when reset hits is discarded
    vb = n_valid;
    apply(1000, 5);
    do_reset(1);
    idle(4);
    check("inflight_discarded", n_valid - vb, 0);
    check("inflight_slope", estimated_slope, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
